// File: rtl/heap_array_arena_if.sv
// Request/response bus between an executor and the heap array arena.
interface heap_array_arena_if #(
    parameter int unsigned WIDTH = 12
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_array;
    logic [WIDTH-1:0] req_index;
    logic [WIDTH-1:0] req_data;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             resp_error;

    modport master (
        output req_valid, req_op, req_array, req_index, req_data,
        input  req_ready, resp_valid, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_op, req_array, req_index, req_data,
        output req_ready, resp_valid, resp_data, resp_error
    );
endinterface

// File: rtl/heap_array_arena.sv
// Heap arena of fixed-area arrays: alloc/free with LIFO handle reuse, length
// tracking and element read/write/push/pop/size over a single-port sync RAM.
module heap_array_arena #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned NARRAYS = 16,
    parameter int unsigned NAREA   = 8
) (
    input  logic              clock,
    input  logic              reset,
    heap_array_arena_if.slave bus,
    output logic [WIDTH-1:0]  allocs,
    output logic [WIDTH-1:0]  max_allocs
);
    localparam int unsigned HW    = $clog2(NARRAYS);
    localparam int unsigned AW    = $clog2(NAREA);
    localparam int unsigned SW    = AW + 1;
    localparam int unsigned CW    = HW + 1;
    localparam int unsigned MW    = HW + AW;
    localparam int unsigned DEPTH = NARRAYS * NAREA;

    localparam logic [2:0] OP_ALLOC = 3'd0;
    localparam logic [2:0] OP_FREE  = 3'd1;
    localparam logic [2:0] OP_READ  = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_PUSH  = 3'd4;
    localparam logic [2:0] OP_POP   = 3'd5;
    localparam logic [2:0] OP_SIZE  = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] arr_q, arr_d, idx_q, idx_d, dat_q, dat_d;
    logic [SW-1:0]    size_q [NARRAYS];
    logic [SW-1:0]    size_d [NARRAYS];
    logic [HW-1:0]    stack_q [NARRAYS];
    logic [HW-1:0]    stack_d [NARRAYS];
    logic [NARRAYS-1:0] alloc_q, alloc_d;
    logic [CW-1:0]    top_q, top_d, fresh_q, fresh_d;
    logic [WIDTH-1:0] allocs_q, allocs_d, max_q, max_d;
    logic             err_q, err_d, use_ram_q, use_ram_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
    logic             req_ready_q, req_ready_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] ram_rd_q;
    logic             ram_we_c;
    logic [MW-1:0]    ram_addr_c;
    logic [WIDTH-1:0] ram_wdata_c;

    logic             h_ok_c, live_c;
    logic [HW-1:0]    hnd_c, new_h_c;
    logic [SW-1:0]    cur_size_c;
    logic [WIDTH-1:0] allocs_inc_c;

    // Full-width handle compare: any upper bit set is out of range.
    assign h_ok_c       = arr_q < WIDTH'(NARRAYS);
    assign hnd_c        = arr_q[HW-1:0];
    assign live_c       = h_ok_c && alloc_q[hnd_c];
    assign cur_size_c   = size_q[hnd_c];
    assign allocs_inc_c = allocs_q + WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arr_d        = arr_q;
        idx_d        = idx_q;
        dat_d        = dat_q;
        size_d       = size_q;
        stack_d      = stack_q;
        alloc_d      = alloc_q;
        top_d        = top_q;
        fresh_d      = fresh_q;
        allocs_d     = allocs_q;
        max_d        = max_q;
        err_d        = err_q;
        use_ram_d    = use_ram_q;
        res_d        = res_q;
        resp_valid_d = 1'b0;
        resp_error_d = resp_error_q;
        resp_data_d  = resp_data_q;
        ram_we_c     = 1'b0;
        ram_addr_c   = {hnd_c, idx_q[AW-1:0]};
        ram_wdata_c  = dat_q;
        new_h_c      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    op_d    = bus.req_op;
                    arr_d   = bus.req_array;
                    idx_d   = bus.req_index;
                    dat_d   = bus.req_data;
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                err_d     = 1'b0;
                use_ram_d = 1'b0;
                res_d     = '0;
                state_d   = S_RESP;
                case (op_q)
                    OP_ALLOC: begin
                        if (top_q != '0) begin
                            new_h_c = stack_q[HW'(top_q - CW'(1))];
                            top_d   = top_q - CW'(1);
                        end else if (fresh_q != CW'(NARRAYS)) begin
                            new_h_c = HW'(fresh_q);
                            fresh_d = fresh_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                        if (!err_d) begin
                            size_d[new_h_c]  = '0;
                            alloc_d[new_h_c] = 1'b1;
                            allocs_d         = allocs_inc_c;
                            if (allocs_inc_c > max_q) max_d = allocs_inc_c;
                            res_d            = WIDTH'(new_h_c);
                        end
                    end
                    OP_FREE: begin
                        if (!live_c) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[HW'(top_q)] = hnd_c;
                            top_d               = top_q + CW'(1);
                            alloc_d[hnd_c]      = 1'b0;
                            allocs_d            = allocs_q - WIDTH'(1);
                        end
                    end
                    OP_READ: begin
                        if (!live_c || idx_q >= WIDTH'(cur_size_c)) err_d = 1'b1;
                        else use_ram_d = 1'b1;
                    end
                    OP_WRITE: begin
                        if (!live_c || idx_q >= WIDTH'(NAREA)) begin
                            err_d = 1'b1;
                        end else begin
                            ram_we_c = 1'b1;
                            if (idx_q >= WIDTH'(cur_size_c))
                                size_d[hnd_c] = SW'(idx_q[AW-1:0]) + SW'(1);
                        end
                    end
                    OP_PUSH: begin
                        if (!live_c || cur_size_c == SW'(NAREA)) begin
                            err_d = 1'b1;
                        end else begin
                            ram_addr_c    = {hnd_c, AW'(cur_size_c)};
                            ram_we_c      = 1'b1;
                            size_d[hnd_c] = cur_size_c + SW'(1);
                        end
                    end
                    OP_POP: begin
                        if (!live_c || cur_size_c == '0) begin
                            err_d = 1'b1;
                        end else begin
                            ram_addr_c    = {hnd_c, AW'(cur_size_c - SW'(1))};
                            use_ram_d     = 1'b1;
                            size_d[hnd_c] = cur_size_c - SW'(1);
                        end
                    end
                    OP_SIZE: begin
                        if (!live_c) err_d = 1'b1;
                        else res_d = WIDTH'(cur_size_c);
                    end
                    default: err_d = 1'b1;
                endcase
            end
            S_RESP: begin
                resp_valid_d = 1'b1;
                resp_error_d = err_q;
                resp_data_d  = err_q ? '0 : (use_ram_q ? ram_rd_q : res_q);
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            arr_q        <= '0;
            idx_q        <= '0;
            dat_q        <= '0;
            for (int unsigned i = 0; i < NARRAYS; i++) begin
                size_q[i]  <= '0;
                stack_q[i] <= '0;
            end
            alloc_q      <= '0;
            top_q        <= '0;
            fresh_q      <= '0;
            allocs_q     <= '0;
            max_q        <= '0;
            err_q        <= 1'b0;
            use_ram_q    <= 1'b0;
            res_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arr_q        <= arr_d;
            idx_q        <= idx_d;
            dat_q        <= dat_d;
            size_q       <= size_d;
            stack_q      <= stack_d;
            alloc_q      <= alloc_d;
            top_q        <= top_d;
            fresh_q      <= fresh_d;
            allocs_q     <= allocs_d;
            max_q        <= max_d;
            err_q        <= err_d;
            use_ram_q    <= use_ram_d;
            res_q        <= res_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_data_q  <= resp_data_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // Heap RAM: contents are not reset.
    always_ff @(posedge clock) begin
        if (ram_we_c) mem[ram_addr_c] <= ram_wdata_c;
        ram_rd_q <= mem[ram_addr_c];
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_error = resp_error_q;
    assign allocs         = allocs_q;
    assign max_allocs     = max_q;
endmodule

// File: tb/tb_heap_array_arena.sv
// Directed bench for heap_array_arena with hand-computed expectations.
module tb_heap_array_arena;
    localparam int unsigned W = 12;

    logic clock;
    logic reset;
    logic [W-1:0] allocs, max_allocs;
    int total, bad;

    heap_array_arena_if #(.WIDTH(W)) bus_if ();

    heap_array_arena #(.WIDTH(W), .NARRAYS(16), .NAREA(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_if.slave),
        .allocs     (allocs),
        .max_allocs (max_allocs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_req(input logic [2:0] op, input logic [W-1:0] arr,
                          input logic [W-1:0] idx, input logic [W-1:0] dat,
                          output logic [W-1:0] rdata, output logic rerr, output int lat);
        int guard;
        @(negedge clock);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_array = arr;
        bus_if.req_index = idx;
        bus_if.req_data  = dat;
        guard = 0;
        while (!bus_if.req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 20) begin
            $display("FAIL req_ready_timeout got=0 exp=1");
            bad++;
            total++;
        end
        @(posedge clock);
        #1 bus_if.req_valid = 1'b0;
        lat = 0;
        rdata = '0;
        rerr = 1'b0;
        while (lat < 10) begin
            @(posedge clock);
            lat++;
            #1;
            if (bus_if.resp_valid) break;
        end
        if (!bus_if.resp_valid) begin
            $display("FAIL resp_timeout op=%0d got=0 exp=1", op);
            bad++;
            total++;
        end
        rdata = bus_if.resp_data;
        rerr  = bus_if.resp_error;
    endtask

    task automatic test_reset();
        logic [W-1:0] d; logic e; int lat;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++; if (bus_if.req_ready !== 1'b1) begin $display("FAIL rst_ready got=%0b exp=1", bus_if.req_ready); bad++; end
        total++; if (bus_if.resp_valid !== 1'b0) begin $display("FAIL rst_resp_valid got=%0b exp=0", bus_if.resp_valid); bad++; end
        total++; if (allocs !== 12'd0) begin $display("FAIL rst_allocs got=%0d exp=0", allocs); bad++; end
        total++; if (max_allocs !== 12'd0) begin $display("FAIL rst_max got=%0d exp=0", max_allocs); bad++; end
        reset = 1'b1;
        do_req(3'd0, '0, '0, '0, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b0) begin $display("FAIL first_alloc got=%0d/%0b exp=0/0", d, e); bad++; end
        total++; if (lat != 2) begin $display("FAIL first_latency got=%0d exp=2", lat); bad++; end
        @(posedge clock); #1;
        total++; if (bus_if.resp_valid !== 1'b0) begin $display("FAIL resp_pulse_width got=%0b exp=0", bus_if.resp_valid); bad++; end
    endtask

    task automatic test_alloc();
        logic [W-1:0] d; logic e; int lat;
        for (int i = 1; i < 16; i++) begin
            do_req(3'd0, '0, '0, '0, d, e, lat);
            total++; if (d !== W'(i) || e !== 1'b0) begin $display("FAIL alloc_%0d got=%0d/%0b exp=%0d/0", i, d, e, i); bad++; end
        end
        total++; if (allocs !== 12'd16 || max_allocs !== 12'd16) begin $display("FAIL alloc_counts got=%0d/%0d exp=16/16", allocs, max_allocs); bad++; end
        do_req(3'd0, '0, '0, '0, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b1) begin $display("FAIL alloc_full got=%0d/%0b exp=0/1", d, e); bad++; end
        do_req(3'd1, 12'd5, '0, '0, d, e, lat);
        total++; if (e !== 1'b0) begin $display("FAIL free5 got=%0b exp=0", e); bad++; end
        do_req(3'd1, 12'd9, '0, '0, d, e, lat);
        total++; if (e !== 1'b0 || allocs !== 12'd14) begin $display("FAIL free9 got=%0b/%0d exp=0/14", e, allocs); bad++; end
        do_req(3'd0, '0, '0, '0, d, e, lat);
        total++; if (d !== 12'd9 || e !== 1'b0) begin $display("FAIL lifo_first got=%0d/%0b exp=9/0", d, e); bad++; end
        do_req(3'd0, '0, '0, '0, d, e, lat);
        total++; if (d !== 12'd5 || e !== 1'b0) begin $display("FAIL lifo_second got=%0d/%0b exp=5/0", d, e); bad++; end
        total++; if (allocs !== 12'd16 || max_allocs !== 12'd16) begin $display("FAIL realloc_counts got=%0d/%0d exp=16/16", allocs, max_allocs); bad++; end
    endtask

    task automatic test_array_rw();
        logic [W-1:0] d; logic e; int lat;
        do_req(3'd3, 12'd0, 12'd3, 12'd33, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b0) begin $display("FAIL write3 got=%0d/%0b exp=0/0", d, e); bad++; end
        do_req(3'd6, 12'd0, '0, '0, d, e, lat);
        total++; if (d !== 12'd4 || e !== 1'b0) begin $display("FAIL size_after_write got=%0d/%0b exp=4/0", d, e); bad++; end
        do_req(3'd2, 12'd0, 12'd3, '0, d, e, lat);
        total++; if (d !== 12'd33 || e !== 1'b0) begin $display("FAIL read3 got=%0d/%0b exp=33/0", d, e); bad++; end
        do_req(3'd2, 12'd0, 12'd4, '0, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b1) begin $display("FAIL read4 got=%0d/%0b exp=0/1", d, e); bad++; end
        do_req(3'd3, 12'd0, 12'd8, 12'd1, d, e, lat);
        total++; if (e !== 1'b1) begin $display("FAIL write8 got=%0b exp=1", e); bad++; end
        do_req(3'd2, 12'd0, 12'h803, '0, d, e, lat);
        total++; if (e !== 1'b1) begin $display("FAIL read_nowrap got=%0b exp=1", e); bad++; end
        do_req(3'd6, 12'd0, '0, '0, d, e, lat);
        total++; if (d !== 12'd4) begin $display("FAIL size_unchanged got=%0d exp=4", d); bad++; end
    endtask

    task automatic test_push_pop();
        logic [W-1:0] d; logic e; int lat;
        logic [W-1:0] vals [3];
        vals[0] = 12'd33; vals[1] = 12'd22; vals[2] = 12'd11;
        for (int i = 0; i < 3; i++) begin
            do_req(3'd4, 12'd1, '0, vals[i], d, e, lat);
            total++; if (e !== 1'b0) begin $display("FAIL push_%0d got=%0b exp=0", i, e); bad++; end
        end
        do_req(3'd6, 12'd1, '0, '0, d, e, lat);
        total++; if (d !== 12'd3) begin $display("FAIL size_push got=%0d exp=3", d); bad++; end
        for (int i = 2; i >= 0; i--) begin
            do_req(3'd5, 12'd1, '0, '0, d, e, lat);
            total++; if (d !== vals[i] || e !== 1'b0) begin $display("FAIL pop_%0d got=%0d/%0b exp=%0d/0", i, d, e, vals[i]); bad++; end
        end
        do_req(3'd5, 12'd1, '0, '0, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b1) begin $display("FAIL pop_empty got=%0d/%0b exp=0/1", d, e); bad++; end
        for (int i = 0; i < 8; i++) begin
            do_req(3'd4, 12'd1, '0, W'(100 + i), d, e, lat);
            total++; if (e !== 1'b0) begin $display("FAIL fill_%0d got=%0b exp=0", i, e); bad++; end
        end
        do_req(3'd4, 12'd1, '0, 12'd999, d, e, lat);
        total++; if (e !== 1'b1) begin $display("FAIL push_full got=%0b exp=1", e); bad++; end
        do_req(3'd2, 12'd1, 12'd7, '0, d, e, lat);
        total++; if (d !== 12'd107 || e !== 1'b0) begin $display("FAIL read_top got=%0d/%0b exp=107/0", d, e); bad++; end
    endtask

    task automatic test_free();
        logic [W-1:0] d; logic e; int lat;
        do_req(3'd1, 12'd3, '0, '0, d, e, lat);
        total++; if (e !== 1'b0 || allocs !== 12'd15) begin $display("FAIL free3 got=%0b/%0d exp=0/15", e, allocs); bad++; end
        do_req(3'd1, 12'd3, '0, '0, d, e, lat);
        total++; if (e !== 1'b1 || allocs !== 12'd15) begin $display("FAIL double_free got=%0b/%0d exp=1/15", e, allocs); bad++; end
        do_req(3'd2, 12'd3, 12'd0, '0, d, e, lat);
        total++; if (e !== 1'b1) begin $display("FAIL read_freed got=%0b exp=1", e); bad++; end
        do_req(3'd7, 12'd0, '0, '0, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b1) begin $display("FAIL op7 got=%0d/%0b exp=0/1", d, e); bad++; end
        do_req(3'd1, 12'd16, '0, '0, d, e, lat);
        total++; if (e !== 1'b1) begin $display("FAIL free16 got=%0b exp=1", e); bad++; end
        do_req(3'd6, 12'h801, '0, '0, d, e, lat);
        total++; if (e !== 1'b1) begin $display("FAIL size_hibits got=%0b exp=1", e); bad++; end
        do_req(3'd0, '0, '0, '0, d, e, lat);
        total++; if (d !== 12'd3 || e !== 1'b0 || allocs !== 12'd16) begin $display("FAIL realloc3 got=%0d/%0b/%0d exp=3/0/16", d, e, allocs); bad++; end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rdy, rv;
        logic [W-1:0] d5;
        @(negedge clock);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = 3'd6;
        bus_if.req_array = 12'd1;
        bus_if.req_index = '0;
        bus_if.req_data  = '0;
        rdy = '0; rv = '0; d5 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            rdy[c] = bus_if.req_ready;
            rv[c]  = bus_if.resp_valid;
            if (c == 5) d5 = bus_if.resp_data;
            if (c == 3) bus_if.req_valid = 1'b0;
        end
        total++; if (rdy !== 8'b1110_0100) begin $display("FAIL b2b_ready got=%b exp=11100100", rdy); bad++; end
        total++; if (rv !== 8'b0010_0100) begin $display("FAIL b2b_resp got=%b exp=00100100", rv); bad++; end
        total++; if (d5 !== 12'd8) begin $display("FAIL b2b_data got=%0d exp=8", d5); bad++; end
    endtask

    task automatic test_reset_mid_op();
        logic [W-1:0] d; logic e; int lat; int pulses;
        @(negedge clock);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = 3'd0;
        @(posedge clock);
        #2 bus_if.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        total++; if (bus_if.req_ready !== 1'b1 || allocs !== 12'd0 || max_allocs !== 12'd0) begin
            $display("FAIL midrst_state got=%0b/%0d/%0d exp=1/0/0", bus_if.req_ready, allocs, max_allocs); bad++; end
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (bus_if.resp_valid) pulses++;
        end
        total++; if (pulses != 0) begin $display("FAIL midrst_resp got=%0d exp=0", pulses); bad++; end
        do_req(3'd0, '0, '0, '0, d, e, lat);
        total++; if (d !== 12'd0 || e !== 1'b0 || allocs !== 12'd1 || max_allocs !== 12'd1) begin
            $display("FAIL midrst_alloc got=%0d/%0b/%0d/%0d exp=0/0/1/1", d, e, allocs, max_allocs); bad++; end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus_if.req_valid = 1'b0;
        bus_if.req_op    = '0;
        bus_if.req_array = '0;
        bus_if.req_index = '0;
        bus_if.req_data  = '0;
        test_reset();
        test_alloc();
        test_array_rw();
        test_push_pop();
        test_free();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
